// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: NDEV device windows plus an interrupt controller window.
// Optional macro BRIDGE_LEVEL_IRQ_EN: level-sensitive interrupts that bypass the pending register.
module sys_bridge_n #(
  parameter int unsigned NDEV       = 3,
  parameter logic [31:0] BASE       = 32'h00007F00,
  parameter logic [31:0] DEFAULT_RD = 32'h11111111
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            praddr,
  input  logic [31:0]            prwd,
  input  logic                   prreq,
  input  logic                   prwe,
  output logic [31:0]            prrd,
  output logic                   prready,
  input  logic [32*NDEV-1:0]     dev_rd,
  input  logic [NDEV-1:0]        dev_irq,
  output logic [1:0]             devaddr,
  output logic [31:0]            devwd,
  output logic [NDEV-1:0]        dev_we,
  output logic [5:0]             hwint
);

  typedef enum logic {StIdle, StResp} state_e;

  state_e            state_q, state_d;
  logic [31:0]       prrd_q, prrd_d;
  logic [NDEV-1:0]   mask_q, mask_d;
  logic [15:0]       errcnt_q, errcnt_d;
  logic [NDEV-1:0]   hwint_q, hwint_d;
  logic [NDEV-1:0]   pend_view;

  logic [27:0]       win;
  logic              aligned, ctl_hit, mapped, accept, ctl_wr;
  logic [NDEV-1:0]   hit;
  logic [31:0]       rd_mux;

`ifndef BRIDGE_LEVEL_IRQ_EN
  logic [NDEV-1:0]   irq_q, pend_q, pend_d;
  assign pend_view = pend_q;
`else
  assign pend_view = dev_irq;
`endif

  assign devaddr = praddr[3:2];
  assign devwd   = prwd;
  assign prrd    = prrd_q;
  assign prready = (state_q == StResp);
  assign accept  = (state_q == StIdle) && prreq;
  assign ctl_wr  = accept && prwe && ctl_hit;

  // BASE is 16-byte aligned, so the window index is a difference of the upper bits.
  always_comb begin
    win     = praddr[31:4] - BASE[31:4];
    aligned = (praddr[1:0] == 2'b00);
    hit     = '0;
    rd_mux  = DEFAULT_RD;
    for (int i = 0; i < NDEV; i++) begin
      if (aligned && (win == 28'(i))) begin
        hit[i] = 1'b1;
        rd_mux = dev_rd[32*i +: 32];
      end
    end
    ctl_hit = aligned && (win == 28'(NDEV));
    if (ctl_hit) begin
      unique case (praddr[3:2])
        2'd0:    rd_mux = 32'(pend_view);
        2'd1:    rd_mux = 32'(mask_q);
        2'd2:    rd_mux = 32'(errcnt_q);
        default: rd_mux = 32'h0;
      endcase
    end
    mapped = (|hit) || ctl_hit;
  end

  assign dev_we = (accept && prwe) ? hit : '0;

  always_comb begin
    state_d  = state_q;
    prrd_d   = prrd_q;
    mask_d   = mask_q;
    errcnt_d = errcnt_q;
    unique case (state_q)
      StIdle: begin
        if (prreq) begin
          state_d = StResp;
          prrd_d  = rd_mux;
          if (!mapped && (errcnt_q != 16'hFFFF)) errcnt_d = errcnt_q + 16'd1;
          if (ctl_wr && (praddr[3:2] == 2'd1)) mask_d = prwd[NDEV-1:0];
          if (ctl_wr && (praddr[3:2] == 2'd2)) errcnt_d = 16'h0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifndef BRIDGE_LEVEL_IRQ_EN
  // A rising edge in the same cycle as a write-1-clear keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (ctl_wr && (praddr[3:2] == 2'd0)) pend_d = pend_q & ~prwd[NDEV-1:0];
    pend_d = pend_d | (dev_irq & ~irq_q);
  end
  assign hwint_d = pend_q & mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= dev_irq;
      pend_q <= pend_d;
    end
  end
`else
  assign hwint_d = dev_irq & mask_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      prrd_q   <= '0;
      mask_q   <= '1;
      errcnt_q <= '0;
      hwint_q  <= '0;
    end else begin
      state_q  <= state_d;
      prrd_q   <= prrd_d;
      mask_q   <= mask_d;
      errcnt_q <= errcnt_d;
      hwint_q  <= hwint_d;
    end
  end

  always_comb begin
    hwint             = '0;
    hwint[NDEV-1:0]   = hwint_q;
  end

  always_ff @(posedge clk) begin
    assert (NDEV >= 1 && NDEV <= 6)
      else $error("sys_bridge_n: NDEV=%0d outside 1..6", NDEV);
  end

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed self-checking bench for sys_bridge_n with NDEV=3, BASE=0x7F00.
module tb_sys_bridge_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] praddr, prwd, prrd, devwd;
  logic        prreq, prwe, prready;
  logic [95:0] dev_rd;
  logic [2:0]  dev_irq, dev_we;
  logic [1:0]  devaddr;
  logic [5:0]  hwint;

  int n_checks = 0;
  int n_fail   = 0;

  sys_bridge_n #(
    .NDEV       (3),
    .BASE       (32'h00007F00),
    .DEFAULT_RD (32'h11111111)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .praddr  (praddr),
    .prwd    (prwd),
    .prreq   (prreq),
    .prwe    (prwe),
    .prrd    (prrd),
    .prready (prready),
    .dev_rd  (dev_rd),
    .dev_irq (dev_irq),
    .devaddr (devaddr),
    .devwd   (devwd),
    .dev_we  (dev_we),
    .hwint   (hwint)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge with the bridge idle.
  task automatic bus_access(input string tag, input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input logic [2:0] exp_we,
                            input logic chk_rd, input logic [31:0] exp_rd);
    praddr = a;
    prwe   = we;
    prwd   = wd;
    prreq  = 1'b1;
    #1;
    check({tag, ".acc_we"}, 32'(dev_we), 32'(exp_we));
    check({tag, ".acc_rdy"}, 32'(prready), 32'h0);
    @(posedge clk);
    #1;
    prreq = 1'b0;
    prwe  = 1'b0;
    check({tag, ".rsp_rdy"}, 32'(prready), 32'h1);
    check({tag, ".rsp_we"}, 32'(dev_we), 32'h0);
    if (chk_rd) check({tag, ".rd"}, prrd, exp_rd);
    step();
    check({tag, ".done_rdy"}, 32'(prready), 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    praddr  = '0;
    prwd    = '0;
    prreq   = 1'b0;
    prwe    = 1'b0;
    dev_irq = '0;
    dev_rd  = {32'hCCCC0002, 32'hBBBB0001, 32'hA5A5A5A5};
    step();
    step();
    reset = 1'b0;
    check("rst.prready", 32'(prready), 32'h0);
    check("rst.prrd", prrd, 32'h0);
    check("rst.hwint", 32'(hwint), 32'h0);
    check("rst.dev_we", 32'(dev_we), 32'h0);
    bus_access("rd_mask_rst", 32'h7F34, 1'b0, 32'h0, 3'b000, 1'b1, 32'h7);

    bus_access("rd_dev0", 32'h7F04, 1'b0, 32'h0, 3'b000, 1'b1, 32'hA5A5A5A5);

    praddr = 32'h7F14;
    prwd   = 32'h12345678;
    #1;
    check("wr_dev1.devaddr", 32'(devaddr), 32'h1);
    check("wr_dev1.devwd", devwd, 32'h12345678);
    bus_access("wr_dev1", 32'h7F14, 1'b1, 32'h12345678, 3'b010, 1'b1, 32'hBBBB0001);
    bus_access("wr_dev2", 32'h7F20, 1'b1, 32'h0, 3'b100, 1'b1, 32'hCCCC0002);

    bus_access("unmap_hi", 32'h7F40, 1'b0, 32'h0, 3'b000, 1'b1, 32'h11111111);
    bus_access("unmap_mis", 32'h7F02, 1'b0, 32'h0, 3'b000, 1'b1, 32'h11111111);
    bus_access("rd_err2", 32'h7F38, 1'b0, 32'h0, 3'b000, 1'b1, 32'h2);
    bus_access("wr_err", 32'h7F38, 1'b1, 32'h5, 3'b000, 1'b0, 32'h0);
    bus_access("rd_err0", 32'h7F38, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0);
    bus_access("rd_ctl_c", 32'h7F3C, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0);

`ifndef BRIDGE_LEVEL_IRQ_EN
    dev_irq = 3'b100;
    step();
    step();
    check("edge.hwint", 32'(hwint), 32'h04);
    bus_access("rd_pend", 32'h7F30, 1'b0, 32'h0, 3'b000, 1'b1, 32'h4);
    bus_access("wr_mask0", 32'h7F34, 1'b1, 32'h0, 3'b000, 1'b0, 32'h0);
    check("mask0.hwint", 32'(hwint), 32'h0);
    bus_access("wr_mask7", 32'h7F34, 1'b1, 32'h7, 3'b000, 1'b0, 32'h0);
    check("mask7.hwint", 32'(hwint), 32'h04);
    bus_access("clr_pend", 32'h7F30, 1'b1, 32'h4, 3'b000, 1'b0, 32'h0);
    check("clr.hwint", 32'(hwint), 32'h0);
    bus_access("rd_pend_clr", 32'h7F30, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0);
    dev_irq = 3'b000;
    step();
    dev_irq = 3'b100;
    bus_access("clr_vs_set", 32'h7F30, 1'b1, 32'h4, 3'b000, 1'b0, 32'h0);
    bus_access("rd_pend_set", 32'h7F30, 1'b0, 32'h0, 3'b000, 1'b1, 32'h4);
    check("set_wins.hwint", 32'(hwint), 32'h04);
`else
    dev_irq = 3'b011;
    #1;
    check("lvl.hwint_pre", 32'(hwint), 32'h0);
    step();
    check("lvl.hwint_on", 32'(hwint), 32'h03);
    bus_access("lvl_rd_pend", 32'h7F30, 1'b0, 32'h0, 3'b000, 1'b1, 32'h3);
    bus_access("lvl_wr_pend", 32'h7F30, 1'b1, 32'h7, 3'b000, 1'b0, 32'h0);
    check("lvl.hwint_wr", 32'(hwint), 32'h03);
    dev_irq = 3'b000;
    step();
    check("lvl.hwint_off", 32'(hwint), 32'h0);
    dev_irq = 3'b100;
`endif

    // Reset arriving while the bridge is presenting a response.
    dev_irq = 3'b000;
    bus_access("wr_mask2", 32'h7F34, 1'b1, 32'h2, 3'b000, 1'b0, 32'h0);
    praddr = 32'h7F04;
    prwe   = 1'b0;
    prreq  = 1'b1;
    step();
    prreq = 1'b0;
    check("rstresp.rdy_before", 32'(prready), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstresp.prready", 32'(prready), 32'h0);
    check("rstresp.hwint", 32'(hwint), 32'h0);
    check("rstresp.prrd", prrd, 32'h0);
    bus_access("rstresp_mask", 32'h7F34, 1'b0, 32'h0, 3'b000, 1'b1, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
